// File: rtl/data_pack_mux_pkg.sv
// Shared constants for data_pack_mux: register map addresses and parameter defaults.
package data_pack_mux_pkg;

  localparam logic [15:0] CTRL_ADDR = 16'h0009;
  localparam logic [15:0] STAT_ADDR = 16'h0008;
  localparam logic [15:0] CNT_BASE  = 16'h0010;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_W0     = 2;
  localparam int DEF_W1     = 6;
  localparam int DEF_DEPTH  = 4;

endpackage

// File: rtl/data_pack_fifo.sv
// Synchronous per-channel FIFO with occupancy count; read data is combinational from the head slot.
module data_pack_fifo
  import data_pack_mux_pkg::*;
#(
  parameter int W     = DEF_W0 + DEF_W1,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Caller guarantees push only when not full or popping, and pop only when not empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/data_pack_mux.sv
// Packs per-channel {high,low} fields into words, buffers each channel, and drains them
// round-robin into a single valid/ready output register; small register bus for control/status.
module data_pack_mux
  import data_pack_mux_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int W0     = DEF_W0,
  parameter int W1     = DEF_W1,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH*W0-1:0]      data_in0,
  input  logic [NUM_CH*W1-1:0]      data_in1,
  input  logic [NUM_CH-1:0]         data_in_vld,
  output logic [W0+W1-1:0]          data_out,
  output logic [$clog2(NUM_CH)-1:0] data_out_ch,
  output logic                      data_out_vld,
  input  logic                      data_out_rdy,
  input  logic                      bus_cs,
  input  logic                      bus_op,
  input  logic [15:0]               bus_addr,
  input  logic [15:0]               bus_wr_data,
  output logic [15:0]               bus_rd_data
);

  localparam int W    = W0 + W1;
  localparam int CH_W = $clog2(NUM_CH);
  localparam int CW   = $clog2(DEPTH) + 1;

  logic [W-1:0]      fifo_dout [NUM_CH];
  logic [CW-1:0]     fifo_cnt  [NUM_CH];
  logic [NUM_CH-1:0] fifo_full, fifo_empty, push, pop, ovf_set, ovf_clr;
  logic [NUM_CH-1:0] en, ovf;
  logic [CH_W-1:0]   rr_ptr, sel;
  logic              found, load_ok;
  logic [15:0]       rd_next;
  logic              unused_wr_bits;

  assign unused_wr_bits = ^bus_wr_data[15:NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign push[c]    = data_in_vld[c] & en[c] & (~fifo_full[c] | pop[c]);
    assign ovf_set[c] = data_in_vld[c] & en[c] & fifo_full[c] & ~pop[c];

    data_pack_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[c]),
      .pop   (pop[c]),
      .din   ({data_in1[c*W1 +: W1], data_in0[c*W0 +: W0]}),
      .dout  (fifo_dout[c]),
      .count (fifo_cnt[c]),
      .full  (fifo_full[c]),
      .empty (fifo_empty[c])
    );
  end

  // Round-robin search begins one past the last served channel.
  always_comb begin
    int idx;
    idx   = 0;
    sel   = rr_ptr;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_CH;
      if (!found && !fifo_empty[idx]) begin
        found = 1'b1;
        sel   = CH_W'(idx);
      end
    end
  end

  // Output handshake: a word transfers on any edge where data_out_vld and data_out_rdy are both 1;
  // while vld=1 and rdy=0 data_out/data_out_ch hold; the register reloads when empty or transferring.
  assign load_ok = !data_out_vld || data_out_rdy;
  assign pop     = (load_ok && found) ? (NUM_CH'(1) << sel) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out     <= '0;
      data_out_ch  <= '0;
      data_out_vld <= 1'b0;
      rr_ptr       <= CH_W'(NUM_CH - 1);
    end else if (load_ok) begin
      data_out_vld <= found;
      if (found) begin
        data_out    <= fifo_dout[sel];
        data_out_ch <= sel;
        rr_ptr      <= sel;
      end
    end
  end

  assign ovf_clr = (bus_cs && bus_op && bus_addr == STAT_ADDR) ? bus_wr_data[NUM_CH-1:0] : '0;

  always_comb begin
    rd_next = '0;
    if (bus_addr == CTRL_ADDR)      rd_next = 16'(en);
    else if (bus_addr == STAT_ADDR) rd_next = 16'(ovf);
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus_addr == CNT_BASE + 16'(c)) rd_next = 16'(fifo_cnt[c]);
    end
  end

  // Overflow set takes priority over a same-cycle write-1-to-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      en          <= '0;
      ovf         <= '0;
      bus_rd_data <= '0;
    end else begin
      if (bus_cs && bus_op && bus_addr == CTRL_ADDR) en <= bus_wr_data[NUM_CH-1:0];
      ovf <= (ovf & ~ovf_clr) | ovf_set;
      if (bus_cs && !bus_op) bus_rd_data <= rd_next;
    end
  end

endmodule

// File: tb/tb_data_pack_mux.sv
// Self-checking bench for data_pack_mux: directed vector table, corner sequences, randomized run vs queue model.
module tb_data_pack_mux;

  localparam int NUM_CH = 4;
  localparam int W0     = 2;
  localparam int W1     = 6;
  localparam int DEPTH  = 4;
  localparam int W      = W0 + W1;
  localparam int CHW    = 2;

  logic                 clk;
  logic                 rst;
  logic [NUM_CH*W0-1:0] data_in0;
  logic [NUM_CH*W1-1:0] data_in1;
  logic [NUM_CH-1:0]    data_in_vld;
  logic [W-1:0]         data_out;
  logic [CHW-1:0]       data_out_ch;
  logic                 data_out_vld;
  logic                 data_out_rdy;
  logic                 bus_cs;
  logic                 bus_op;
  logic [15:0]          bus_addr;
  logic [15:0]          bus_wr_data;
  logic [15:0]          bus_rd_data;

  data_pack_mux #(.NUM_CH(NUM_CH), .W0(W0), .W1(W1), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in0     (data_in0),
    .data_in1     (data_in1),
    .data_in_vld  (data_in_vld),
    .data_out     (data_out),
    .data_out_ch  (data_out_ch),
    .data_out_vld (data_out_vld),
    .data_out_rdy (data_out_rdy),
    .bus_cs       (bus_cs),
    .bus_op       (bus_op),
    .bus_addr     (bus_addr),
    .bus_wr_data  (bus_wr_data),
    .bus_rd_data  (bus_rd_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (queues per channel) ----------------
  logic [W-1:0]      mq [NUM_CH][$];
  logic [W-1:0]      m_out;
  int                m_out_ch;
  bit                m_out_vld;
  logic [NUM_CH-1:0] m_en, m_ovf;
  int                m_last;
  logic [15:0]       m_rd;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) mq[c].delete();
    m_out = '0; m_out_ch = 0; m_out_vld = 0;
    m_en = '0; m_ovf = '0; m_last = NUM_CH - 1; m_rd = '0;
  endtask

  task automatic model_step();
    logic [15:0]       rd;
    logic [NUM_CH-1:0] set_bits, clr_bits;
    bit                found;
    int                c, idx;
    rd = m_rd;
    if (bus_cs && !bus_op) begin
      idx = int'(bus_addr) - 16;
      if (bus_addr == 16'h0009)            rd = 16'(m_en);
      else if (bus_addr == 16'h0008)       rd = 16'(m_ovf);
      else if (idx >= 0 && idx < NUM_CH)   rd = 16'(mq[idx].size());
      else                                 rd = '0;
    end
    if (!m_out_vld || data_out_rdy) begin
      found = 0;
      for (int k = 1; k <= NUM_CH; k++) begin
        c = (m_last + k) % NUM_CH;
        if (!found && mq[c].size() > 0) begin
          found = 1; m_out = mq[c].pop_front(); m_out_ch = c; m_last = c;
        end
      end
      m_out_vld = found;
    end
    set_bits = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (data_in_vld[ch] && m_en[ch]) begin
        if (mq[ch].size() < DEPTH) mq[ch].push_back({data_in1[ch*W1 +: W1], data_in0[ch*W0 +: W0]});
        else set_bits[ch] = 1'b1;
      end
    end
    clr_bits = (bus_cs && bus_op && bus_addr == 16'h0008) ? bus_wr_data[NUM_CH-1:0] : '0;
    m_ovf = (m_ovf & ~clr_bits) | set_bits;
    if (bus_cs && bus_op && bus_addr == 16'h0009) m_en = bus_wr_data[NUM_CH-1:0];
    m_rd = rd;
  endtask

  // ---------------- scoreboard ----------------
  logic [CHW+W-1:0] exp_q[$];
  bit               sb_on = 0;

  task automatic tick();
    if (sb_on && data_out_vld && data_out_rdy) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_extra actual=0x%0h expected=none", {data_out_ch, data_out});
      end else begin
        check("sb_word", {data_out_ch, data_out}, exp_q.pop_front());
      end
    end
    if (rst) model_reset(); else model_step();
    @(posedge clk); #1;
    check("m_vld", data_out_vld, m_out_vld);
    if (m_out_vld) begin
      check("m_data", data_out, m_out);
      check("m_ch", data_out_ch, m_out_ch);
    end
    check("m_rd", bus_rd_data, m_rd);
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    data_in_vld = '0; bus_cs = 0; bus_op = 0; bus_addr = '0; bus_wr_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs(); data_out_rdy = 0; rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic push(input int ch, input logic [W1-1:0] d1, input logic [W0-1:0] d0);
    data_in_vld[ch] = 1'b1;
    data_in1[ch*W1 +: W1] = d1;
    data_in0[ch*W0 +: W0] = d0;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] d);
    bus_cs = 1; bus_op = 1; bus_addr = addr; bus_wr_data = d;
    tick();
    bus_cs = 0; bus_op = 0;
  endtask

  task automatic bus_read(input logic [15:0] addr, input logic [15:0] exp, input string name);
    bus_cs = 1; bus_op = 0; bus_addr = addr;
    tick();
    bus_cs = 0;
    check(name, bus_rd_data, exp);
  endtask

  typedef struct {
    int             ch;
    logic [W1-1:0]  d1;
    logic [W0-1:0]  d0;
    logic [W-1:0]   word;
  } vec_t;

  vec_t vec [4];

  initial begin
    rst = 1; data_in0 = '0; data_in1 = '0; data_out_rdy = 0;
    idle_inputs();
    model_reset();

    vec[0] = '{ch: 2, d1: 6'h2A, d0: 2'h1, word: 8'hA9};
    vec[1] = '{ch: 0, d1: 6'h3F, d0: 2'h3, word: 8'hFF};
    vec[2] = '{ch: 3, d1: 6'h00, d0: 2'h2, word: 8'h02};
    vec[3] = '{ch: 1, d1: 6'h15, d0: 2'h0, word: 8'h54};

    // single-word latency table
    for (int i = 0; i < 4; i++) begin
      do_reset();
      check("rst_vld", data_out_vld, 0);
      check("rst_data", data_out, 0);
      check("rst_ch", data_out_ch, 0);
      check("rst_rd", bus_rd_data, 0);
      bus_write(16'h0009, 16'h000F);
      data_out_rdy = 1;
      push(vec[i].ch, vec[i].d1, vec[i].d0);
      tick();
      data_in_vld = '0;
      check("lat_edge_n", data_out_vld, 0);
      tick();
      check("lat_vld", data_out_vld, 1);
      check("lat_word", data_out, vec[i].word);
      check("lat_ch", data_out_ch, vec[i].ch);
      tick();
      check("lat_one_cycle", data_out_vld, 0);
    end

    // all channels, two cycles, back-to-back round robin
    do_reset();
    bus_write(16'h0009, 16'h000F);
    data_out_rdy = 1; sb_on = 1;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        push(c, 6'(k * 8 + c + 1), 2'(c));
        exp_q.push_back({2'(c), 6'(k * 8 + c + 1), 2'(c)});
      end
      tick();
    end
    data_in_vld = '0;
    check("rr_no_gap", data_out_vld, 1);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("rr_no_gap", data_out_vld, 1);
    end
    tick();
    check("rr_drained", exp_q.size(), 0);
    sb_on = 0;

    // overflow, counts, W1C, then held output and in-order drain
    do_reset();
    bus_write(16'h0009, 16'h0001);
    for (int k = 0; k < 6; k++) begin
      push(0, 6'(k + 1), 2'(k));
      tick();
    end
    data_in_vld = '0;
    bus_read(16'h0008, 16'h0001, "ovf_read");
    bus_read(16'h0010, 16'h0004, "cnt_full");
    bus_write(16'h0008, 16'h0001);
    bus_read(16'h0008, 16'h0000, "ovf_w1c");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_data", data_out, 8'h04);
      check("hold_vld", data_out_vld, 1);
    end
    for (int k = 0; k < 5; k++) exp_q.push_back({2'd0, 6'(k + 1), 2'(k)});
    sb_on = 1; data_out_rdy = 1;
    for (int i = 0; i < 7; i++) tick();
    check("order_drained", exp_q.size(), 0);
    sb_on = 0;

    // overflow set beats same-cycle clear
    do_reset();
    bus_write(16'h0009, 16'h0001);
    for (int k = 0; k < 5; k++) begin
      push(0, 6'h11, 2'(k));
      tick();
    end
    bus_write(16'h0008, 16'h0001);
    data_in_vld = '0;
    bus_read(16'h0008, 16'h0001, "ovf_set_wins");

    // disabled channel, unmapped read, control write timing
    do_reset();
    data_out_rdy = 1;
    push(1, 6'h05, 2'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dis_no_out", data_out_vld, 0);
    end
    bus_write(16'h0009, 16'h0002);
    data_in_vld = '0;
    bus_read(16'h0008, 16'h0000, "dis_no_ovf");
    bus_read(16'h0011, 16'h0000, "dis_cnt");
    bus_write(16'h0009, 16'h0000);
    bus_read(16'h0009, 16'h0000, "ctrl_read0");
    bus_read(16'h1234, 16'h0000, "unmapped");
    push(1, 6'h07, 2'h2);
    bus_write(16'h0009, 16'h0002);
    tick();
    data_in_vld = '0;
    check("ctrl_timing_a", data_out_vld, 0);
    tick();
    check("ctrl_timing_b", data_out_vld, 1);
    check("ctrl_timing_w", data_out, 8'h1E);

    // reset with buffered words
    do_reset();
    bus_write(16'h0009, 16'h000F);
    push(0, 6'h01, 2'h0); push(1, 6'h02, 2'h1); push(2, 6'h03, 2'h2);
    tick();
    data_in_vld = '0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    check("mid_rst_vld", data_out_vld, 0);
    for (int c = 0; c < NUM_CH; c++) bus_read(16'(16 + c), 16'h0000, "mid_rst_cnt");
    bus_read(16'h0009, 16'h0000, "mid_rst_en");
    data_out_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_quiet", data_out_vld, 0);
    end

    // randomized run against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      data_in_vld  = 4'($urandom);
      data_in0     = 8'($urandom);
      data_in1     = 24'($urandom);
      data_out_rdy = ($urandom_range(0, 9) < 7);
      bus_cs = 0; bus_op = 0;
      if ($urandom_range(0, 4) == 0) begin
        bus_cs = 1;
        bus_op = 1'($urandom);
        case ($urandom_range(0, 3))
          0:       bus_addr = 16'h0009;
          1:       bus_addr = 16'h0008;
          2:       bus_addr = 16'(16 + $urandom_range(0, 4));
          default: bus_addr = 16'($urandom);
        endcase
        bus_wr_data = 16'($urandom);
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_pack_mux.md
DATA_PACK_MUX -- requirements
Module: data_pack_mux

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, number of input channels (2..8).
REQ-002 The block SHALL have parameter W0, default 2, low field width per channel.
REQ-003 The block SHALL have parameter W1, default 6, high field width per channel.
REQ-004 The block SHALL have parameter DEPTH, default 4, per-channel FIFO entries (power of 2, >=2).
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 data_in0  input  NUM_CH*W0  low fields; channel c at [c*W0 +: W0].
REQ-008 data_in1  input  NUM_CH*W1  high fields; channel c at [c*W1 +: W1].
REQ-009 data_in_vld  input  NUM_CH  per-channel valid; no backpressure to sources.
REQ-010 data_out  output  W0+W1  packed word {data_in1[c], data_in0[c]}.
REQ-011 data_out_ch  output  $clog2(NUM_CH)  source channel of data_out.
REQ-012 data_out_vld  output  1  data_out/data_out_ch valid.
REQ-013 data_out_rdy  input  1  downstream accept.
REQ-014 bus_cs, bus_op  input  1 each  bus select; op=1 write, op=0 read.
REQ-015 bus_addr, bus_wr_data  input  16 each  register address, write data.
REQ-016 bus_rd_data  output  16  registered read data.

Function
REQ-017 Channel c SHALL push {data_in1[c],data_in0[c]} into FIFO c when data_in_vld[c]=1, CTRL.en[c]=1, and FIFO c is not full or is popped in the same cycle.
REQ-018 A push attempt on an enabled, full FIFO not popped that cycle SHALL drop the word and set STAT.ovf[c].
REQ-019 A disabled channel SHALL ignore data_in_vld, SHALL NOT set ovf, and SHALL keep draining already-buffered words.
REQ-020 Output stage SHALL be a single register; transfer occurs when data_out_vld=1 and data_out_rdy=1.
REQ-021 data_out, data_out_ch SHALL be held stable while data_out_vld=1 and data_out_rdy=0.
REQ-022 When output register is empty or transferring, the block SHALL pop from the next non-empty FIFO in round-robin order starting at (last served channel + 1) mod NUM_CH, loading it at the same edge.
REQ-023 First-word latency: word sampled at edge N into empty FIFO with empty output SHALL show data_out_vld=1 after edge N+1.
REQ-024 Sustained throughput SHALL be one word per cycle with data_out_rdy held 1.
REQ-025 Per-channel order SHALL be preserved; FIFO pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-026 Bus write (cs=1, op=1): addr 0x0009 writes CTRL.en=wr_data[NUM_CH-1:0]; addr 0x0008 clears ovf bits where wr_data bit=1 (W1C); other addresses ignored.
REQ-027 Bus read (cs=1, op=0): bus_rd_data SHALL update at next edge: 0x0009 -> CTRL.en zero-extended; 0x0008 -> ovf zero-extended; 0x0010+c (c<NUM_CH) -> FIFO c count; other -> 0.
REQ-028 bus_rd_data SHALL hold its value when no read is active.
REQ-029 Overflow set and W1C clear of the same bit in one cycle: set SHALL win.
REQ-030 CTRL write taking effect at edge N SHALL govern pushes from edge N+1.

Reset
REQ-031 With rst=1 at an edge: data_out=0, data_out_ch=0, data_out_vld=0, bus_rd_data=0, CTRL.en=0, ovf=0, all FIFOs empty, round-robin pointer=NUM_CH-1.
REQ-032 Reset mid-operation SHALL discard all buffered and output-stage words; no partial transfer afterwards.

Structure
REQ-033 Shared package SHALL hold register address constants (CTRL 0x0009, STAT 0x0008, CNT_BASE 0x0010) and parameter defaults.
REQ-034 Per-channel buffer SHALL be one sub-module, data_pack_fifo (sync FIFO with count output), instantiated NUM_CH times.

Verification
REQ-035 Reset, en=0xF, ch2 pushes 0x2A/0x01 (data_in1=0x2A, data_in0=0x1), rdy=1 -> data_out=0xA9, data_out_ch=2, vld high after 2nd edge, one cycle.
REQ-036 en=0xF, all 4 channels push simultaneously for 2 cycles, rdy=1 -> outputs ch0,1,2,3,0,1,2,3 back-to-back, 8 words, no gaps.
REQ-037 en=0x1, rdy=0, ch0 pushes 6 words -> 1 in output reg, 4 in FIFO, 1 dropped; read 0x0008 -> 0x0001; read 0x0010 -> 4; write 0x0008=0x1 then read -> 0.
REQ-038 rdy=0 with vld=1 for 5 cycles -> data_out unchanged; raise rdy -> remaining words in order.
REQ-039 en=0x0, ch1 vld=1 -> no output, ovf=0; read 0x0009 -> 0; unmapped read 0x1234 -> 0.
REQ-040 Assert rst with 3 words buffered -> next cycle data_out_vld=0, all counts 0, en=0.
